key_event_decoder: RTL and testbench
====================================

Name: key_event_decoder

Overview:
- Consumes the debounced key interface of one button and classifies presses into user-level events.
- The interface is a one-cycle `key_flag` strobe plus a `key_value` level, where 0 = pressed and 1 = released.
- Events produced: single click, double click, long press, and auto-repeat while held.
- Sits between the per-key debouncer and the vending-machine control FSM; one instance per button.

Parameters:
- CNT_W, 26: width of the internal cycle counter. Every *_CYC parameter must be ≤ 2^CNT_W and ≥ 2.
- LONG_CYC, 50_000_000: hold time in cycles before `long_pulse` fires (1 s at 50 MHz).
- REPEAT_CYC, 10_000_000: auto-repeat period in cycles after a long press (0.2 s).
- DCLICK_CYC, 15_000_000: window in cycles after the first release in which a second press counts as a double click (0.3 s).

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- key_flag, input, 1: one-cycle strobe; `key_value` is valid in the same cycle.
- key_value, input, 1: debounced key level; 0 = pressed, 1 = released.
- pressed, output, 1: level, high while the key is considered held.
- single_pulse, output, 1: one-cycle pulse reporting a confirmed single click.
- double_pulse, output, 1: one-cycle pulse reporting a double click.
- long_pulse, output, 1: one-cycle pulse when the hold reaches LONG_CYC.
- repeat_pulse, output, 1: one-cycle pulse every REPEAT_CYC while held past long.

Behaviour:
- Events:
  - PRESS_EV = `key_flag` & (`key_value` == 0).
  - REL_EV = `key_flag` & (`key_value` == 1).
  - A strobe whose value matches the current state is ignored (e.g. PRESS_EV in HELD).
- Reset: state = IDLE, cnt = 0, all outputs 0. Asynchronous, effective mid-operation; no pulse is emitted on reset.
- Registered outputs: all outputs are registered. Each pulse is high for exactly one clk, in the cycle after the triggering event or timeout.
- Counter: cnt clears to 0 on every state change and increments by 1 per clk inside a timed state. A timeout is cnt == X_CYC-1, so a timeout fires exactly X_CYC cycles after state entry.
- State IDLE:
  - PRESS_EV → HELD.
- State HELD:
  - REL_EV → WAIT2.
  - LONG_CYC timeout → `long_pulse`, go to LONG.
- State LONG:
  - Each REPEAT_CYC timeout → `repeat_pulse`, cnt = 0, stay in LONG.
  - REL_EV → IDLE, no click pulse.
- State WAIT2:
  - PRESS_EV → HELD2.
  - DCLICK_CYC timeout → `single_pulse`, go to IDLE.
- State HELD2:
  - REL_EV → `double_pulse`, go to IDLE.
  - LONG_CYC timeout → `single_pulse` and `long_pulse` in the same cycle, go to LONG.
- pressed: 1 in HELD, LONG and HELD2; 0 otherwise. Registered from the next state, so it rises the cycle after PRESS_EV.
- Priority: an event beats a timeout in the same cycle in every state. Examples: REL_EV on the HELD timeout cycle gives WAIT2 with no `long_pulse`; PRESS_EV on the WAIT2 timeout cycle gives HELD2 with no `single_pulse`.
- No-wrap guarantee: every timed state exits or clears cnt at its timeout, so cnt never wraps.
- Mutual exclusion: at most one of `double_pulse` and `repeat_pulse` is ever high in a cycle. `single_pulse` and `long_pulse` coincide only on the HELD2 timeout.

Test Plan (LONG_CYC=20, REPEAT_CYC=5, DCLICK_CYC=8, CNT_W=8):
- Single click: PRESS_EV at t0, REL_EV at t0+5 → `pressed` high t0+1..t0+5. `single_pulse` is one cycle, 8 cycles after WAIT2 entry. No other pulses.
- Double click: press t0, release t0+4, press t0+7, release t0+10 → one `double_pulse` the cycle after the t0+10 strobe. No `single_pulse`.
- Long and repeat: press at t0, held 36 cycles → `long_pulse` at 20 cycles after HELD entry, then `repeat_pulse` at +5, +10, +15. Release → IDLE with no click pulse.
- Priority: REL_EV on exactly the 20th HELD cycle → no `long_pulse`, state WAIT2. PRESS_EV on the 8th WAIT2 cycle → no `single_pulse`, state HELD2.
- Redundant strobes: `key_flag` with `key_value`=0 while in HELD → ignored, cnt not cleared, `long_pulse` timing unchanged. `key_flag` with 1 in IDLE → no output.
- Reset mid-LONG: `rst_n` low while in LONG → all outputs 0 immediately (asynchronous). After release of `rst_n`, a new press behaves as from IDLE.

Source files
------------

// File: rtl/key_event_decoder.sv
// Classifies debounced key strobes into single click, double click, long press
// and auto-repeat events; one instance per button.
module key_event_decoder #(
    parameter int unsigned CNT_W      = 26,
    parameter int unsigned LONG_CYC   = 50_000_000,
    parameter int unsigned REPEAT_CYC = 10_000_000,
    parameter int unsigned DCLICK_CYC = 15_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_flag,
    input  logic key_value,
    output logic pressed,
    output logic single_pulse,
    output logic double_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    typedef enum logic [2:0] {
        IDLE,
        HELD,
        LONG,
        WAIT2,
        HELD2
    } state_t;

    // Timeouts compare against X_CYC-1 so the event lands X_CYC cycles after entry
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYC - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             press_ev, rel_ev;
    logic             pressed_nxt;
    logic             single_nxt, double_nxt, long_nxt, repeat_nxt;

    assign press_ev = key_flag & ~key_value;
    assign rel_ev   = key_flag &  key_value;

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            pressed      <= 1'b0;
            single_pulse <= 1'b0;
            double_pulse <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            pressed      <= pressed_nxt;
            single_pulse <= single_nxt;
            double_pulse <= double_nxt;
            long_pulse   <= long_nxt;
            repeat_pulse <= repeat_nxt;
        end
    end

    // Next state and pulse decode; events take priority over timeouts
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        single_nxt = 1'b0;
        double_nxt = 1'b0;
        long_nxt   = 1'b0;
        repeat_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (press_ev) state_nxt = HELD;
            end
            HELD: begin
                if (rel_ev) begin
                    state_nxt = WAIT2;
                end else if (cnt == LONG_LAST) begin
                    long_nxt  = 1'b1;
                    state_nxt = LONG;
                end
            end
            LONG: begin
                if (rel_ev) begin
                    state_nxt = IDLE;
                end else if (cnt == REPEAT_LAST) begin
                    repeat_nxt = 1'b1;
                end
            end
            WAIT2: begin
                if (press_ev) begin
                    state_nxt = HELD2;
                end else if (cnt == DCLICK_LAST) begin
                    single_nxt = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            HELD2: begin
                if (rel_ev) begin
                    double_nxt = 1'b1;
                    state_nxt  = IDLE;
                end else if (cnt == LONG_LAST) begin
                    single_nxt = 1'b1;
                    long_nxt   = 1'b1;
                    state_nxt  = LONG;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Counter restarts on any state change and on each repeat period
        if ((state_nxt != state) || repeat_nxt) begin
            cnt_nxt = '0;
        end else if (state != IDLE) begin
            cnt_nxt = cnt + CNT_W'(1);
        end

        pressed_nxt = (state_nxt == HELD) || (state_nxt == LONG) || (state_nxt == HELD2);
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder: gesture table plus reset-mid-LONG sequence.
module tb_key_event_decoder;

    localparam int unsigned CNT_W      = 8;
    localparam int unsigned LONG_CYC   = 20;
    localparam int unsigned REPEAT_CYC = 5;
    localparam int unsigned DCLICK_CYC = 8;
    localparam int          ROW_CYC    = 60;

    logic clk = 1'b0;
    logic rst_n;
    logic key_flag;
    logic key_value;
    logic pressed, single_pulse, double_pulse, long_pulse, repeat_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    key_event_decoder #(
        .CNT_W     (CNT_W),
        .LONG_CYC  (LONG_CYC),
        .REPEAT_CYC(REPEAT_CYC),
        .DCLICK_CYC(DCLICK_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_flag    (key_flag),
        .key_value   (key_value),
        .pressed     (pressed),
        .single_pulse(single_pulse),
        .double_pulse(double_pulse),
        .long_pulse  (long_pulse),
        .repeat_pulse(repeat_pulse)
    );

    always #5 clk = ~clk;

    // Gesture: press strobe at cycle 0, then optional strobes; -1 means unused.
    // Expected cycle numbers are those in which the registered output is high.
    typedef struct {
        string name;
        int    rel1;
        int    press2;
        int    rel2;
        int    xcyc;
        logic  xval;
        int    exp_single;
        int    exp_double;
        int    exp_long;
        int    exp_nrep;
        int    exp_rep1;
        int    exp_rise;
        int    exp_fall;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_row(input vec_t v);
        int first_single = -1, first_double = -1, first_long = -1, first_rep = -1;
        int n_single = 0, n_double = 0, n_long = 0, n_rep = 0;
        int rise = -1, fall = -1, clash = 0;
        logic prev_pressed = 1'b0;
        for (int k = 0; k < ROW_CYC; k++) begin
            @(negedge clk);
            if (single_pulse) begin n_single++; if (first_single < 0) first_single = k; end
            if (double_pulse) begin n_double++; if (first_double < 0) first_double = k; end
            if (long_pulse)   begin n_long++;   if (first_long < 0)   first_long   = k; end
            if (repeat_pulse) begin n_rep++;    if (first_rep < 0)    first_rep    = k; end
            if (double_pulse && repeat_pulse) clash++;
            if (pressed && !prev_pressed && rise < 0) rise = k;
            if (!pressed && prev_pressed) fall = k;
            prev_pressed = pressed;
            key_flag  = 1'b0;
            key_value = 1'b1;
            if (k == 0 || k == v.press2) begin
                key_flag  = 1'b1;
                key_value = 1'b0;
            end else if (k == v.rel1 || k == v.rel2) begin
                key_flag  = 1'b1;
                key_value = 1'b1;
            end else if (k == v.xcyc) begin
                key_flag  = 1'b1;
                key_value = v.xval;
            end
        end
        chk({v.name, " single_at"}, first_single, v.exp_single);
        chk({v.name, " single_cnt"}, n_single, (v.exp_single >= 0) ? 1 : 0);
        chk({v.name, " double_at"}, first_double, v.exp_double);
        chk({v.name, " double_cnt"}, n_double, (v.exp_double >= 0) ? 1 : 0);
        chk({v.name, " long_at"}, first_long, v.exp_long);
        chk({v.name, " long_cnt"}, n_long, (v.exp_long >= 0) ? 1 : 0);
        chk({v.name, " repeat_cnt"}, n_rep, v.exp_nrep);
        chk({v.name, " repeat_first"}, first_rep, v.exp_rep1);
        chk({v.name, " pressed_rise"}, rise, v.exp_rise);
        chk({v.name, " pressed_fall"}, fall, v.exp_fall);
        chk({v.name, " dbl_rep_clash"}, clash, 0);
    endtask

    initial begin
        //          name          rel1 p2  r2  xc  xv    sgl dbl lng nrep rep1 rise fall
        vecs[0] = '{"single",       5, -1, -1, -1, 1'b0, 14, -1, -1, 0, -1, 1,  6};
        vecs[1] = '{"double",       4,  7, 10, -1, 1'b0, -1, 11, -1, 0, -1, 1, 11};
        vecs[2] = '{"long_repeat", 36, -1, -1, -1, 1'b0, -1, -1, 21, 3, 26, 1, 37};
        vecs[3] = '{"prio_held",   20, -1, -1, -1, 1'b0, 29, -1, -1, 0, -1, 1, 21};
        vecs[4] = '{"prio_wait2",   4, 12, 15, -1, 1'b0, -1, 16, -1, 0, -1, 1, 16};
        vecs[5] = '{"held2_long",   3,  6, 33, -1, 1'b0, 27, -1, 27, 1, 32, 1, 34};
        vecs[6] = '{"dup_press",   22, -1, -1, 10, 1'b0, -1, -1, 21, 0, -1, 1, 23};
        vecs[7] = '{"dup_rel_idle", 5, -1, -1, 25, 1'b1, 14, -1, -1, 0, -1, 1,  6};
        vecs[8] = '{"dup_rel_wait", 5, -1, -1,  9, 1'b1, 14, -1, -1, 0, -1, 1,  6};

        rst_n     = 1'b0;
        key_flag  = 1'b0;
        key_value = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({pressed, single_pulse, double_pulse, long_pulse, repeat_pulse}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) run_row(vecs[i]);

        // Reset mid-LONG: press at cycle 0, first repeat visible in cycle 26
        for (int k = 0; k <= 26; k++) begin
            @(negedge clk);
            key_flag  = (k == 0);
            key_value = (k == 0) ? 1'b0 : 1'b1;
        end
        chk("pre_reset_repeat", int'(repeat_pulse), 1);
        chk("pre_reset_pressed", int'(pressed), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'({pressed, single_pulse, double_pulse, long_pulse, repeat_pulse}), 0);
        repeat (2) @(negedge clk);
        chk("held_reset_outputs", int'({pressed, single_pulse, double_pulse, long_pulse, repeat_pulse}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_row(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
